// File: rtl/traffic_lights_cmd_master_if.sv
// Host/command bundle between a configuration host, the command master and
// the traffic-light controller's cmd_type/cmd_valid/cmd_data port.
interface traffic_lights_cmd_master_if #(
  parameter int WIDTH = 16
);
  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [WIDTH-1:0] cfg_green_i;
  logic [WIDTH-1:0] cfg_red_i;
  logic [WIDTH-1:0] cfg_yellow_i;
  logic             cfg_run_i;
  logic             off_req_i;
  logic             busy_o;
  logic [2:0]       cmd_type_o;
  logic             cmd_valid_o;
  logic [WIDTH-1:0] cmd_data_o;
  logic [1:0]       mode_o;

  modport master (
    input  cfg_valid_i, cfg_green_i, cfg_red_i, cfg_yellow_i, cfg_run_i, off_req_i,
    output cfg_ready_o, busy_o, cmd_type_o, cmd_valid_o, cmd_data_o, mode_o
  );

  modport slave (
    output cfg_valid_i, cfg_green_i, cfg_red_i, cfg_yellow_i, cfg_run_i, off_req_i,
    input  cfg_ready_o, busy_o, cmd_type_o, cmd_valid_o, cmd_data_o, mode_o
  );
endinterface

// File: rtl/traffic_lights_cmd_master.sv
// Expands one host configuration into the controller's legal command sequence
// (NOTRANSITION, SET_GREEN, SET_RED, SET_YELLOW, NORMAL) and issues SHUTDOWN on request.
module traffic_lights_cmd_master #(
  parameter int WIDTH      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        clk_i,
  input  logic                        srst_i,
  traffic_lights_cmd_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE_S, NT_S, SETG_S, SETR_S, SETY_S, RUN_S, OFF_S, GAP_S
  } state_t;

  localparam logic [2:0] CMD_NORMAL   = 3'd0;
  localparam logic [2:0] CMD_SHUTDOWN = 3'd1;
  localparam logic [2:0] CMD_NOTRANS  = 3'd2;
  localparam logic [2:0] CMD_SETG     = 3'd3;
  localparam logic [2:0] CMD_SETR     = 3'd4;
  localparam logic [2:0] CMD_SETY     = 3'd5;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_NT     = 2'd2;

  localparam int           GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // A zero time would stall the controller, so the shortest legal phase is one tick.
  function automatic logic [WIDTH-1:0] sat_time(input logic [WIDTH-1:0] t);
    return (t == '0) ? WIDTH'(1) : t;
  endfunction

  function automatic state_t seq_after(input state_t cur, input logic run);
    case (cur)
      NT_S:    return SETG_S;
      SETG_S:  return SETR_S;
      SETR_S:  return SETY_S;
      SETY_S:  return run ? RUN_S : IDLE_S;
      default: return IDLE_S;
    endcase
  endfunction

  function automatic logic [2:0] cmd_code(input state_t s);
    case (s)
      NT_S:    return CMD_NOTRANS;
      SETG_S:  return CMD_SETG;
      SETR_S:  return CMD_SETR;
      SETY_S:  return CMD_SETY;
      OFF_S:   return CMD_SHUTDOWN;
      default: return CMD_NORMAL;
    endcase
  endfunction

  state_t           state, last_cmd, launch_st;
  logic [GW-1:0]    gap_cnt;
  logic [WIDTH-1:0] green_p0, red_p0, yellow_p0;
  logic             run_p0;
  logic             off_pending;
  logic             vld_p1, busy_p1;
  logic [2:0]       type_p1;
  logic [WIDTH-1:0] data_p1, launch_data;
  logic [1:0]       mode_p1;
  logic             ready, hs, launch_go;

  assign ready = (state == IDLE_S) && !off_pending;
  assign hs    = bus.cfg_valid_i && ready;

  // Decide which command (if any) gets registered onto the bus at the next edge.
  always_comb begin
    launch_go = 1'b0;
    launch_st = IDLE_S;
    case (state)
      IDLE_S: begin
        if (hs) begin
          launch_go = 1'b1;
          launch_st = (mode_p1 == MODE_NT) ? SETG_S : NT_S;
        end else if ((off_pending || bus.off_req_i) && mode_p1 != MODE_IDLE) begin
          launch_go = 1'b1;
          launch_st = OFF_S;
        end
      end
      GAP_S: begin
        if (gap_cnt == GAP_LAST) begin
          launch_st = seq_after(last_cmd, run_p0);
          launch_go = (launch_st != IDLE_S);
        end
      end
      default: begin
        if (GAP_CYCLES == 0) begin
          launch_st = seq_after(state, run_p0);
          launch_go = (launch_st != IDLE_S);
        end
      end
    endcase

    case (launch_st)
      SETG_S:  launch_data = (state == IDLE_S) ? sat_time(bus.cfg_green_i) : green_p0;
      SETR_S:  launch_data = red_p0;
      SETY_S:  launch_data = yellow_p0;
      default: launch_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state       <= IDLE_S;
      last_cmd    <= IDLE_S;
      gap_cnt     <= '0;
      off_pending <= 1'b0;
      vld_p1      <= 1'b0;
      type_p1     <= CMD_NORMAL;
      data_p1     <= '0;
      mode_p1     <= MODE_IDLE;
      busy_p1     <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;

      if (hs) begin
        green_p0  <= sat_time(bus.cfg_green_i);
        red_p0    <= sat_time(bus.cfg_red_i);
        yellow_p0 <= sat_time(bus.cfg_yellow_i);
        run_p0    <= bus.cfg_run_i;
      end

      if (launch_go) begin
        state    <= launch_st;
        last_cmd <= launch_st;
        vld_p1   <= 1'b1;
        type_p1  <= cmd_code(launch_st);
        data_p1  <= launch_data;
        busy_p1  <= 1'b1;
        case (launch_st)
          NT_S:    mode_p1 <= MODE_NT;
          RUN_S:   mode_p1 <= MODE_NORMAL;
          OFF_S:   mode_p1 <= MODE_IDLE;
          default: ;
        endcase
      end else begin
        case (state)
          IDLE_S: ;
          GAP_S: begin
            if (gap_cnt == GAP_LAST) begin
              state   <= IDLE_S;
              busy_p1 <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            if (GAP_CYCLES == 0) begin
              state   <= IDLE_S;
              busy_p1 <= 1'b0;
            end else begin
              state   <= GAP_S;
              gap_cnt <= '0;
            end
          end
        endcase
      end

      // Requests arriving while busy are merged into a single deferred SHUTDOWN.
      if (launch_go && launch_st == OFF_S)
        off_pending <= 1'b0;
      else if (state == IDLE_S && off_pending && mode_p1 == MODE_IDLE)
        off_pending <= 1'b0;
      else if (bus.off_req_i && (state != IDLE_S || hs))
        off_pending <= 1'b1;
    end
  end

  assign bus.cfg_ready_o = ready;
  assign bus.busy_o      = busy_p1;
  assign bus.cmd_valid_o = vld_p1;
  assign bus.cmd_type_o  = type_p1;
  assign bus.cmd_data_o  = data_p1;
  assign bus.mode_o      = mode_p1;

endmodule

// File: tb/tb_traffic_lights_cmd_master.sv
// Bench for traffic_lights_cmd_master: two instances (GAP_CYCLES 2 and 0) against a
// schedule-based reference model, plus literal strobe timelines from hand calculation.
module tb_traffic_lights_cmd_master;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  traffic_lights_cmd_master_if #(.WIDTH(W)) ifa ();
  traffic_lights_cmd_master_if #(.WIDTH(W)) ifb ();

  traffic_lights_cmd_master #(.WIDTH(W), .GAP_CYCLES(2)) dut_a (.clk_i(clk), .srst_i(rst_a), .bus(ifa));
  traffic_lights_cmd_master #(.WIDTH(W), .GAP_CYCLES(0)) dut_b (.clk_i(clk), .srst_i(rst_b), .bus(ifb));

  int n_vec = 0, n_miss = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a configuration becomes a list of commands, strobe k due at
  // start + k*(gap+1); busy lasts until start + n*(gap+1).
  int gp [2] = '{2, 0};
  int sc_t [2][6];
  int sc_d [2][6];
  int sc_n [2];
  int sc_start [2];
  int bu [2];
  bit m_pend [2];
  bit m_valid [2];
  int m_type [2];
  int m_data [2];
  int m_mode [2];

  task automatic m_add(input int i, input int t, input int d);
    sc_t[i][sc_n[i]] = t;
    sc_d[i][sc_n[i]] = d;
    sc_n[i]++;
  endtask

  task automatic step(input int i, input logic rst, input logic v, input logic [W-1:0] g,
                      input logic [W-1:0] r, input logic [W-1:0] y, input logic run, input logic off);
    bit busy_prev, rdy, hs;
    int now, dd, k;
    busy_prev = cyc < bu[i];
    rdy = !busy_prev && !m_pend[i];
    now = cyc + 1;
    if (rst) begin
      sc_n[i] = 0; bu[i] = 0; m_pend[i] = 0; m_valid[i] = 0;
      m_type[i] = 0; m_data[i] = 0; m_mode[i] = 0;
      return;
    end
    m_valid[i] = 0;
    hs = v && rdy;
    if (off && (busy_prev || hs)) m_pend[i] = 1;
    if (hs) begin
      sc_n[i] = 0;
      if (m_mode[i] != 2) m_add(i, 2, 0);
      m_add(i, 3, (g == 0) ? 1 : int'(g));
      m_add(i, 4, (r == 0) ? 1 : int'(r));
      m_add(i, 5, (y == 0) ? 1 : int'(y));
      if (run) m_add(i, 0, 0);
      sc_start[i] = now;
      bu[i] = now + sc_n[i] * (gp[i] + 1);
    end else if (!busy_prev && (m_pend[i] || off)) begin
      if (m_mode[i] != 0) begin
        sc_n[i] = 0;
        m_add(i, 1, 0);
        sc_start[i] = now;
        bu[i] = now + gp[i] + 1;
      end
      m_pend[i] = 0;
    end
    dd = now - sc_start[i];
    if (sc_n[i] > 0 && dd >= 0 && dd % (gp[i] + 1) == 0 && dd / (gp[i] + 1) < sc_n[i]) begin
      k = dd / (gp[i] + 1);
      m_valid[i] = 1;
      m_type[i] = sc_t[i][k];
      m_data[i] = sc_d[i][k];
      if (m_type[i] == 2) m_mode[i] = 2;
      else if (m_type[i] == 0) m_mode[i] = 1;
      else if (m_type[i] == 1) m_mode[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    step(0, rst_a, ifa.cfg_valid_i, ifa.cfg_green_i, ifa.cfg_red_i, ifa.cfg_yellow_i, ifa.cfg_run_i, ifa.off_req_i);
    step(1, rst_b, ifb.cfg_valid_i, ifb.cfg_green_i, ifb.cfg_red_i, ifb.cfg_yellow_i, ifb.cfg_run_i, ifb.off_req_i);
    cyc++;
  end

  task automatic cmp(input int i, input logic v, input logic [2:0] t, input logic [W-1:0] d,
                     input logic b, input logic [1:0] m, input logic r);
    string p;
    p = (i == 0) ? "a" : "b";
    chk({p, ".cmd_valid"}, 32'(v), 32'(m_valid[i]));
    chk({p, ".cmd_type"},  32'(t), m_type[i]);
    chk({p, ".cmd_data"},  32'(d), m_data[i]);
    chk({p, ".busy"},      32'(b), 32'(cyc < bu[i]));
    chk({p, ".mode"},      32'(m), m_mode[i]);
    chk({p, ".cfg_ready"}, 32'(r), 32'(!(cyc < bu[i]) && !m_pend[i]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, ifa.cmd_valid_o, ifa.cmd_type_o, ifa.cmd_data_o, ifa.busy_o, ifa.mode_o, ifa.cfg_ready_o);
      cmp(1, ifb.cmd_valid_o, ifb.cmd_type_o, ifb.cmd_data_o, ifb.busy_o, ifb.mode_o, ifb.cfg_ready_o);
    end
  end

  // Strobe log for the literal timeline checks.
  typedef struct { int c; int t; int d; } ev_t;
  ev_t qa[$];
  ev_t qb[$];
  always @(negedge clk) begin
    if (ifa.cmd_valid_o === 1'b1) qa.push_back('{cyc, int'(ifa.cmd_type_o), int'(ifa.cmd_data_o)});
    if (ifb.cmd_valid_o === 1'b1) qb.push_back('{cyc, int'(ifb.cmd_type_o), int'(ifb.cmd_data_o)});
  end

  task automatic check_ev(input int which, input int idx, input int c, input int t, input int d);
    ev_t e;
    int sz;
    sz = (which == 0) ? qa.size() : qb.size();
    if (idx >= sz) begin
      chk($sformatf("ev%0d_%0d.present", which, idx), sz, idx + 1);
      return;
    end
    e = (which == 0) ? qa[idx] : qb[idx];
    chk($sformatf("ev%0d_%0d.cycle", which, idx), e.c, c);
    chk($sformatf("ev%0d_%0d.type", which, idx), e.t, t);
    chk($sformatf("ev%0d_%0d.data", which, idx), e.d, d);
  endtask

  task automatic set_in(input int which, input logic v, input int g, input int r, input int y,
                        input logic run, input logic off);
    if (which == 0) begin
      ifa.cfg_valid_i = v; ifa.cfg_green_i = W'(g); ifa.cfg_red_i = W'(r);
      ifa.cfg_yellow_i = W'(y); ifa.cfg_run_i = run; ifa.off_req_i = off;
    end else begin
      ifb.cfg_valid_i = v; ifb.cfg_green_i = W'(g); ifb.cfg_red_i = W'(r);
      ifb.cfg_yellow_i = W'(y); ifb.cfg_run_i = run; ifb.off_req_i = off;
    end
  endtask

  task automatic do_cfg(input int which, input int g, input int r, input int y,
                        input logic run, input logic off, output int t);
    int n;
    logic rdy;
    @(negedge clk);
    set_in(which, 1'b1, g, r, y, run, 1'b0);
    n = 0;
    rdy = (which == 0) ? ifa.cfg_ready_o : ifb.cfg_ready_o;
    while (rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      rdy = (which == 0) ? ifa.cfg_ready_o : ifb.cfg_ready_o;
    end
    chk("handshake_wait_in_budget", 32'(n < 100), 1);
    if (which == 0) ifa.off_req_i = off; else ifb.off_req_i = off;
    t = cyc;
    @(negedge clk);
    set_in(which, 1'b0, g, r, y, run, 1'b0);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_off(input int which, input int c);
    wait_to(c);
    if (which == 0) ifa.off_req_i = 1'b1; else ifb.off_req_i = 1'b1;
    @(negedge clk);
    if (which == 0) ifa.off_req_i = 1'b0; else ifb.off_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, b;
    bit saw_setr;
    rst_a = 1'b1;
    rst_b = 1'b1;
    set_in(0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    set_in(1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk_en = 1;
    chk("a.reset_ready", 32'(ifa.cfg_ready_o), 1);
    chk("a.reset_busy",  32'(ifa.busy_o), 0);
    chk("a.reset_valid", 32'(ifa.cmd_valid_o), 0);
    chk("a.reset_mode",  32'(ifa.mode_o), 0);
    chk("a.reset_data",  32'(ifa.cmd_data_o), 0);

    // Full run from IDLE with the default gap.
    b = qa.size();
    do_cfg(0, 7, 5, 3, 1'b1, 1'b0, t);
    wait_to(t + 15);
    chk("a.t1_ready_before_end", 32'(ifa.cfg_ready_o), 0);
    wait_to(t + 16);
    chk("a.t1_ready_at_end", 32'(ifa.cfg_ready_o), 1);
    chk("a.t1_mode", 32'(ifa.mode_o), 1);
    check_ev(0, b + 0, t + 1, 2, 0);
    check_ev(0, b + 1, t + 4, 3, 7);
    check_ev(0, b + 2, t + 7, 4, 5);
    check_ev(0, b + 3, t + 10, 5, 3);
    check_ev(0, b + 4, t + 13, 0, 0);
    chk("a.t1_count", qa.size(), b + 5);

    // From NORMAL, run=0 with a zero green time.
    b = qa.size();
    do_cfg(0, 0, 4, 2, 1'b0, 1'b0, t);
    wait_to(t + 16);
    check_ev(0, b + 0, t + 1, 2, 0);
    check_ev(0, b + 1, t + 4, 3, 1);
    check_ev(0, b + 2, t + 7, 4, 4);
    check_ev(0, b + 3, t + 10, 5, 2);
    chk("a.t2_count", qa.size(), b + 4);
    chk("a.t2_mode", 32'(ifa.mode_o), 2);

    // Shutdown requested during SET_RED, then again while pending.
    b = qa.size();
    do_cfg(0, 1, 2, 3, 1'b1, 1'b0, t);
    pulse_off(0, t + 4);
    pulse_off(0, t + 6);
    wait_to(t + 30);
    check_ev(0, b + 0, t + 1, 3, 1);
    check_ev(0, b + 1, t + 4, 4, 2);
    check_ev(0, b + 2, t + 7, 5, 3);
    check_ev(0, b + 3, t + 10, 0, 0);
    check_ev(0, b + 4, t + 14, 1, 0);
    chk("a.t3_count", qa.size(), b + 5);
    chk("a.t3_mode", 32'(ifa.mode_o), 0);

    // Shutdown with the controller already idle does nothing.
    b = qa.size();
    pulse_off(0, cyc + 1);
    repeat (3) @(negedge clk);
    chk("a.t4_busy", 32'(ifa.busy_o), 0);
    chk("a.t4_ready", 32'(ifa.cfg_ready_o), 1);
    chk("a.t4_count", qa.size(), b);

    // Reset in the gap after SET_GREEN aborts the sequence.
    b = qa.size();
    do_cfg(0, 7, 5, 3, 1'b1, 1'b0, t);
    wait_to(t + 5);
    rst_a = 1'b1;
    @(negedge clk);
    chk("a.t5_valid", 32'(ifa.cmd_valid_o), 0);
    chk("a.t5_busy", 32'(ifa.busy_o), 0);
    chk("a.t5_mode", 32'(ifa.mode_o), 0);
    chk("a.t5_ready", 32'(ifa.cfg_ready_o), 1);
    rst_a = 1'b0;
    wait_to(t + 25);
    chk("a.t5_count", qa.size(), b + 2);
    saw_setr = 0;
    for (int k = b; k < qa.size(); k++) if (qa[k].t == 4) saw_setr = 1;
    chk("a.t5_no_set_red", 32'(saw_setr), 0);

    // Zero-gap instance: back-to-back strobes.
    b = qb.size();
    do_cfg(1, 0, 0, 0, 1'b0, 1'b0, t);
    wait_to(t + 8);
    check_ev(1, b + 0, t + 1, 2, 0);
    check_ev(1, b + 1, t + 2, 3, 1);
    check_ev(1, b + 2, t + 3, 4, 1);
    check_ev(1, b + 3, t + 4, 5, 1);
    chk("b.t6_mode", 32'(ifb.mode_o), 2);

    // Handshake and shutdown on the same cycle: configuration first, then SHUTDOWN.
    b = qb.size();
    do_cfg(1, 9, 8, 6, 1'b1, 1'b1, t);
    wait_to(t + 12);
    check_ev(1, b + 0, t + 1, 3, 9);
    check_ev(1, b + 1, t + 2, 4, 8);
    check_ev(1, b + 2, t + 3, 5, 6);
    check_ev(1, b + 3, t + 4, 0, 0);
    check_ev(1, b + 4, t + 6, 1, 0);
    chk("b.t7_count", qb.size(), b + 5);
    chk("b.t7_mode", 32'(ifb.mode_o), 0);

    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/traffic_lights_cmd_master.md
Name: traffic_lights_cmd_master

Overview:
Command initiator for the traffic-light controller's cmd_type/cmd_valid/cmd_data interface. It accepts one configuration request from a host over a valid/ready handshake and expands it into the legal command sequence. That sequence is: enter NOTRANSITION if needed, SET_GREEN, SET_RED, SET_YELLOW, then optionally NORMAL. It also issues SHUTDOWN on request and keeps a mirror of the controller's mode.

Parameters:
WIDTH, 16, width of time fields and cmd_data_o (equals the controller's WIDTH).
GAP_CYCLES, 2, idle cycles inserted after every issued command (0 = back-to-back commands).

Ports:
clk_i  in  1  clock
srst_i  in  1  synchronous reset, active-high
cfg_valid_i  in  1  host configuration request valid
cfg_ready_o  out  1  master can accept a configuration
cfg_green_i  in  WIDTH  green time
cfg_red_i  in  WIDTH  red time
cfg_yellow_i  in  WIDTH  yellow time
cfg_run_i  in  1  1 = finish the sequence with NORMAL; 0 = stay in NOTRANSITION
off_req_i  in  1  single-cycle shutdown request
busy_o  out  1  command sequence in progress
cmd_type_o  out  3  command code: 0 NORMAL, 1 SHUTDOWN, 2 NOTRANSITION, 3 SET_GREEN, 4 SET_RED, 5 SET_YELLOW
cmd_valid_o  out  1  command strobe, exactly one cycle per command
cmd_data_o  out  WIDTH  command data
mode_o  out  2  controller mode mirror: 0 IDLE, 1 NORMAL, 2 NOTRANSITION

Behaviour:
- Reset values: cmd_valid_o=0, cmd_type_o=0, cmd_data_o=0, busy_o=0, mode_o=IDLE, shutdown-pending flag cleared, FSM in IDLE_S.
- srst_i mid-sequence aborts immediately; no further commands are issued.
- Command outputs are registered. cfg_ready_o = (FSM in IDLE_S) and not off_pending. It is 1 on the first cycle after reset.
- Handshake: a transfer occurs when cfg_valid_i && cfg_ready_o.
  - cfg_green_i, cfg_red_i, cfg_yellow_i and cfg_run_i are captured on that cycle.
  - Each captured time of 0 is replaced by 1.
  - busy_o rises the next cycle.
- FSM states: IDLE_S, NT_S, SETG_S, SETR_S, SETY_S, RUN_S, OFF_S, GAP_S.
- Every command state drives cmd_valid_o=1 for one cycle with its type and data, then enters GAP_S for GAP_CYCLES cycles. GAP_S is skipped when GAP_CYCLES=0.
- Sequence after handshake at cycle T:
  - First command at T+1.
  - Successive commands every GAP_CYCLES+1 cycles.
  - NT_S is issued only if mode_o != NOTRANSITION; otherwise SETG_S comes first.
  - RUN_S (NORMAL) is issued only if cfg_run_i=1.
- cmd_data_o:
  - SET_* commands carry the captured time.
  - All other commands carry 0.
  - Between strobes, cmd_type_o and cmd_data_o hold their last value.
- mode_o updates in the cycle the corresponding strobe is issued:
  - NOTRANSITION → 2.
  - NORMAL → 1.
  - SHUTDOWN → 0.
  - SET_* leave mode_o unchanged.
- After the final command's gap completes, the FSM returns to IDLE_S and busy_o falls.
- Shutdown:
  - A pulse on off_req_i while the FSM is not in IDLE_S, or on the handshake cycle itself, sets off_pending.
  - From IDLE_S with off_pending set, or with off_req_i and no handshake: if mode_o != IDLE, go to OFF_S, issue SHUTDOWN, then its gap. If mode_o = IDLE, issue nothing and clear off_pending.
  - busy_o is 1 during OFF_S and its gap.
  - Multiple off_req_i pulses while pending merge into one SHUTDOWN.
- Simultaneous handshake and off_req_i in IDLE_S: the configuration runs first, then SHUTDOWN.
- cfg_valid_i while cfg_ready_o=0 is ignored; the host holds it until ready.

Test Plan:
- Mode IDLE; cfg green=7, red=5, yellow=3, run=1, GAP=2; handshake at T -> strobes (2,0)@T+1, (3,7)@T+4, (4,5)@T+7, (5,3)@T+10, (0,0)@T+13; mode_o=1; cfg_ready_o high again at T+16.
- After the previous run (mode_o=1), cfg green=0, red=4, yellow=2, run=0 -> NOTRANSITION, then SET_GREEN data=1, SET_RED 4, SET_YELLOW 2; no NORMAL; final mode_o=2.
- From mode_o=2, cfg run=1 with GAP=0 -> four back-to-back strobes 3,4,5,0 on consecutive cycles, no NOTRANSITION; final mode_o=1.
- off_req_i pulsed mid-sequence (during SETR_S) -> sequence completes unchanged, then one SHUTDOWN strobe (1,0) after the final gap; mode_o=0; a second pulse while pending produces no extra strobe.
- off_req_i with mode_o=IDLE -> no strobe, busy_o stays 0, cfg_ready_o stays 1.
- srst_i asserted during GAP_S after SET_GREEN -> next cycle cmd_valid_o=0, busy_o=0, mode_o=0, cfg_ready_o=1, and no SET_RED strobe is ever emitted.
